// File: rtl/cpu_core.sv
// cpu_core: single-cycle 19-bit core with a 32 x 19 register file.
// Every un-halted clock edge executes one instruction, writes back and moves the PC.
// Optional feature macro: CPU_HALT_EN. When defined, opcode 1111 halts the core
// until reset. When undefined, opcode 1111 is a NOP.
module cpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instruction,
    output logic [18:0] pc_out,
    input  logic [18:0] mem_data_in,
    output logic [18:0] mem_address,
    output logic [18:0] mem_data_out,
    output logic        mem_write
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_INC = 4'b0111;
    localparam logic [3:0] OP_DEC = 4'b1000;
    localparam logic [3:0] OP_LD  = 4'b1001;
    localparam logic [3:0] OP_ST  = 4'b1010;
    localparam logic [3:0] OP_JMP = 4'b1011;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_BNE = 4'b1101;
    localparam logic [3:0] OP_SHL = 4'b1110;
    localparam logic [3:0] OP_SYS = 4'b1111;

    logic [3:0]  op;
    logic [4:0]  fa;
    logic [4:0]  fb;
    logic [4:0]  fc;
    logic [18:0] rf [32];
    logic [18:0] ra;
    logic [18:0] rb;
    logic [18:0] rc;
    logic [18:0] ea;
    logic [18:0] pc_reg;
    logic [18:0] pc_inc;
    logic [18:0] pc_next;
    logic [18:0] wr_data;
    logic        wr_en;
    logic        active;
    logic [18:0] addr_next;
    logic [18:0] sdata_next;
    logic        write_next;

    assign op = instruction[18:15];
    assign fa = instruction[14:10];
    assign fb = instruction[9:5];
    assign fc = instruction[4:0];

    assign ra = rf[fa];
    assign rb = rf[fb];
    assign rc = rf[fc];
    assign ea = rb + {14'b0, fc};
    assign pc_inc = pc_reg + 19'd1;
    assign pc_out = pc_reg;

`ifdef CPU_HALT_EN
    logic halted_reg;

    // Halted flag: set by HALT, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            halted_reg <= 1'b0;
        else if (active && op == OP_SYS)
            halted_reg <= 1'b1;
    end

    assign active = ~reset & ~halted_reg;
`else
    assign active = ~reset;
`endif

    // R0 is hard-wired to zero; R1..R31 are individual registers.
    assign rf[0] = 19'd0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [18:0] r_reg;

            // Write-back into this register when it is the destination.
            always_ff @(posedge clk) begin
                if (reset)
                    r_reg <= 19'd0;
                else if (wr_en && fa == 5'(gi))
                    r_reg <= wr_data;
            end

            assign rf[gi] = r_reg;
        end
    endgenerate

    // Decode: result, next PC and memory-port values for the presented instruction.
    always_comb begin
        wr_data    = 19'd0;
        wr_en      = 1'b0;
        pc_next    = pc_inc;
        addr_next  = 19'd0;
        sdata_next = 19'd0;
        write_next = 1'b0;
        case (op)
            OP_ADD: begin wr_data = rb + rc; wr_en = 1'b1; end
            OP_SUB: begin wr_data = rb - rc; wr_en = 1'b1; end
            OP_MUL: begin wr_data = rb * rc; wr_en = 1'b1; end
            OP_AND: begin wr_data = rb & rc; wr_en = 1'b1; end
            OP_OR:  begin wr_data = rb | rc; wr_en = 1'b1; end
            OP_XOR: begin wr_data = rb ^ rc; wr_en = 1'b1; end
            OP_NOT: begin wr_data = ~rb;     wr_en = 1'b1; end
            OP_INC: begin wr_data = ra + 19'd1; wr_en = 1'b1; end
            OP_DEC: begin wr_data = ra - 19'd1; wr_en = 1'b1; end
            OP_LD: begin
                addr_next = ea;
                wr_data   = mem_data_in;
                wr_en     = 1'b1;
            end
            OP_ST: begin
                addr_next  = ea;
                sdata_next = ra;
                write_next = 1'b1;
            end
            OP_JMP: pc_next = {4'b0, fa, fb, fc};
            OP_BEQ: if (ra == rb) pc_next = pc_inc + {{14{fc[4]}}, fc};
            OP_BNE: if (ra != rb) pc_next = pc_inc + {{14{fc[4]}}, fc};
            OP_SHL: begin
                wr_data = (rc[4:0] >= 5'd19) ? 19'd0 : (rb << rc[4:0]);
                wr_en   = 1'b1;
            end
            OP_SYS: begin
`ifdef CPU_HALT_EN
                pc_next = pc_reg;
`else
                pc_next = pc_inc;
`endif
            end
            default: pc_next = pc_inc;
        endcase
        if (!active) begin
            wr_en      = 1'b0;
            addr_next  = 19'd0;
            sdata_next = 19'd0;
            write_next = 1'b0;
        end
    end

    assign mem_address  = addr_next;
    assign mem_data_out = sdata_next;
    assign mem_write    = write_next;

    // Program counter: cleared by reset, held while halted.
    always_ff @(posedge clk) begin
        if (reset)
            pc_reg <= 19'd0;
        else if (active)
            pc_reg <= pc_next;
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed self-checking bench for cpu_core.
// Register contents are observed through ST instructions on the memory port.
// Build with or without CPU_HALT_EN; the HALT section adapts to the macro.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] instruction = 19'd0;
    logic [18:0] pc_out;
    logic [18:0] mem_data_in = 19'd0;
    logic [18:0] mem_address;
    logic [18:0] mem_data_out;
    logic        mem_write;

    int checks = 0;
    int failures = 0;

    cpu_core dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .mem_data_in  (mem_data_in),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_write    (mem_write)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] enc(input logic [3:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] c);
        return {op, a, b, c};
    endfunction

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
        $display("check %-12s observed=%05h expected=%05h", tag, obs, exp);
    endtask

    // Present an instruction and let it settle before checking combinational outputs.
    task automatic present(input logic [18:0] ins, input logic [18:0] din);
        instruction = ins;
        mem_data_in = din;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and execute it without checks.
    task automatic run(input logic [18:0] ins, input logic [18:0] din);
        present(ins, din);
        edge_step();
    endtask

    // Execute a store and check the address/data it drives.
    task automatic store(input string tag, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [18:0] exp_addr,
                         input logic [18:0] exp_data);
        present(enc(4'b1010, a, b, c), 19'h7FFF0);
        chk({tag, "_addr"}, mem_address, exp_addr);
        chk({tag, "_data"}, mem_data_out, exp_data);
        chk({tag, "_we"}, {18'b0, mem_write}, 19'd1);
        edge_step();
    endtask

    initial begin
        // Reset with a store presented: memory outputs must stay quiet.
        present(enc(4'b1010, 5'd1, 5'd2, 5'd3), 19'd0);
        edge_step();
        edge_step();
        chk("rst_pc", pc_out, 19'd0);
        chk("rst_we", {18'b0, mem_write}, 19'd0);
        chk("rst_addr", mem_address, 19'd0);
        chk("rst_data", mem_data_out, 19'd0);
        reset = 1'b0;

        // LD R1 <- mem[R2+0] = 0x0000F
        present(enc(4'b1001, 5'd1, 5'd2, 5'd0), 19'h0000F);
        chk("ld_addr", mem_address, 19'd0);
        chk("ld_we", {18'b0, mem_write}, 19'd0);
        edge_step();
        chk("ld_pc", pc_out, 19'd1);

        // ST R1 -> mem[R2+0]
        store("st_r1", 5'd1, 5'd2, 5'd0, 19'd0, 19'h0000F);
        chk("st_pc", pc_out, 19'd2);

        run(enc(4'b1001, 5'd2, 5'd0, 5'd0), 19'd5);     // R2 = 5
        run(enc(4'b1001, 5'd3, 5'd0, 5'd0), 19'd7);     // R3 = 7
        present(enc(4'b0000, 5'd4, 5'd2, 5'd3), 19'h12345);
        chk("alu_addr", mem_address, 19'd0);
        chk("alu_data", mem_data_out, 19'd0);
        chk("alu_we", {18'b0, mem_write}, 19'd0);
        edge_step();                                    // R4 = 12
        store("add", 5'd4, 5'd2, 5'd31, 19'd36, 19'd12);

        run(enc(4'b1001, 5'd5, 5'd0, 5'd0), 19'h7FFFF); // R5 = 0x7FFFF
        store("ea_wrap", 5'd5, 5'd5, 5'd2, 19'd1, 19'h7FFFF);
        run(enc(4'b0111, 5'd5, 5'd0, 5'd0), 19'd0);     // INC R5 -> 0
        store("inc_wrap", 5'd5, 5'd0, 5'd0, 19'd0, 19'd0);

        run(enc(4'b1001, 5'd0, 5'd0, 5'd0), 19'h00123); // LD R0 discarded
        store("r0", 5'd0, 5'd0, 5'd0, 19'd0, 19'd0);

        run(enc(4'b0001, 5'd6, 5'd2, 5'd3), 19'd0);     // R6 = 5-7
        store("sub", 5'd6, 5'd0, 5'd0, 19'd0, 19'h7FFFE);

        run(enc(4'b1001, 5'd8, 5'd0, 5'd0), 19'h00401); // R8 = 1025
        run(enc(4'b0010, 5'd9, 5'd8, 5'd8), 19'd0);     // R9 = 1025^2 mod 2^19
        store("mul", 5'd9, 5'd0, 5'd0, 19'd0, 19'h00801);

        run(enc(4'b0101, 5'd10, 5'd2, 5'd3), 19'd0);    // R10 = 5^7 = 2
        run(enc(4'b0110, 5'd11, 5'd10, 5'd0), 19'd0);   // R11 = ~2
        store("not", 5'd11, 5'd0, 5'd0, 19'd0, 19'h7FFFD);

        run(enc(4'b0011, 5'd15, 5'd2, 5'd3), 19'd0);    // R15 = 5&7 = 5
        run(enc(4'b0100, 5'd16, 5'd15, 5'd10), 19'd0);  // R16 = 5|2 = 7
        store("and_or", 5'd16, 5'd0, 5'd0, 19'd0, 19'd7);

        run(enc(4'b1110, 5'd12, 5'd3, 5'd2), 19'd0);    // R12 = 7<<5
        store("shl", 5'd12, 5'd0, 5'd0, 19'd0, 19'h000E0);
        run(enc(4'b1001, 5'd13, 5'd0, 5'd0), 19'd19);   // R13 = 19
        run(enc(4'b1110, 5'd14, 5'd3, 5'd13), 19'd0);   // shift 19 -> 0
        store("shl19", 5'd14, 5'd0, 5'd0, 19'd0, 19'd0);

        run(enc(4'b1000, 5'd2, 5'd0, 5'd0), 19'd0);     // DEC R2 -> 4
        store("dec", 5'd2, 5'd0, 5'd0, 19'd0, 19'd4);

        // Control flow
        run({4'b1011, 15'h1234}, 19'd0);
        chk("jmp", pc_out, 19'h01234);
        run({4'b1011, 15'd5}, 19'd0);
        run(enc(4'b1100, 5'd1, 5'd1, 5'b11110), 19'd0);
        chk("beq_back", pc_out, 19'd4);
        run({4'b1011, 15'd5}, 19'd0);
        run(enc(4'b1101, 5'd1, 5'd1, 5'b11110), 19'd0);
        chk("bne_fall", pc_out, 19'd6);
        run(enc(4'b1101, 5'd2, 5'd3, 5'd3), 19'd0);     // 4 != 7 -> 6+1+3
        chk("bne_taken", pc_out, 19'd10);

        // Opcode 1111 at PC=3
        run({4'b1011, 15'd3}, 19'd0);
        run({4'b1111, 15'd0}, 19'd0);
`ifdef CPU_HALT_EN
        chk("halt_pc", pc_out, 19'd3);
        present(enc(4'b1010, 5'd1, 5'd2, 5'd3), 19'd0);
        chk("halt_we", {18'b0, mem_write}, 19'd0);
        chk("halt_addr", mem_address, 19'd0);
        chk("halt_data", mem_data_out, 19'd0);
        edge_step();
        chk("halt_pc2", pc_out, 19'd3);
`else
        chk("nop_pc", pc_out, 19'd4);
        present(enc(4'b1010, 5'd1, 5'd2, 5'd3), 19'd0);
        chk("nop_we", {18'b0, mem_write}, 19'd1);
        edge_step();
`endif

        // One reset edge, then execution resumes from a clean state.
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        chk("rst2_pc", pc_out, 19'd0);
        store("rst2_r1", 5'd1, 5'd0, 5'd0, 19'd0, 19'd0);
        chk("resume_pc", pc_out, 19'd1);
        run(enc(4'b1100, 5'd0, 5'd0, 5'b11101), 19'd0); // 1+1-3 wraps
        chk("pc_neg", pc_out, 19'h7FFFF);
        run(enc(4'b0000, 5'd0, 5'd0, 5'd0), 19'd0);
        chk("pc_wrap", pc_out, 19'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 No parameters; word width fixed at 19 bits, register file fixed at 32 x 19 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instruction  input  19  current instruction: opcode [18:15], fa [14:10], fb [9:5], fc [4:0].
REQ-005 pc_out  output  19  current program counter (registered).
REQ-006 mem_data_in  input  19  load data from data memory, sampled at the executing edge.
REQ-007 mem_address  output  19  data memory address (combinational).
REQ-008 mem_data_out  output  19  store data (combinational).
REQ-009 mem_write  output  1  store strobe, high for the whole cycle of a store (combinational).

Function
REQ-010 Single-cycle core: each rising clk edge with reset low and not halted executes `instruction`, updates the register file, and updates the PC.
REQ-011 Registers R0..R31; R0 reads 0; writes to R0 are discarded.
REQ-012 Default next PC = PC+1 modulo 2^19 (0x7FFFF wraps to 0).
REQ-013 Opcodes 0000 ADD, 0001 SUB, 0010 MUL (low 19 bits), 0011 AND, 0100 OR, 0101 XOR: R[fa] <= R[fb] op R[fc], arithmetic modulo 2^19, no flags.
REQ-014 0110 NOT: R[fa] <= ~R[fb]; 0111 INC: R[fa] <= R[fa]+1; 1000 DEC: R[fa] <= R[fa]-1 (all wrap).
REQ-015 1001 LD: mem_address = R[fb] + zero-extended fc; R[fa] <= mem_data_in at the edge; mem_write = 0.
REQ-016 1010 ST: mem_address = R[fb] + zero-extended fc; mem_data_out = R[fa]; mem_write = 1; no register written.
REQ-017 For non-LD/ST opcodes, mem_address = 0 and mem_data_out = 0; mem_write = 1 only for ST.
REQ-018 1011 JMP: PC <= zero-extended {fa,fb,fc} (15 bits).
REQ-019 1100 BEQ / 1101 BNE: compare R[fa] with R[fb]; if taken, PC <= PC+1+sign-extended fc (modulo 2^19); otherwise PC+1.
REQ-020 1110 SHL: R[fa] <= R[fb] << R[fc][4:0]; shift amounts >= 19 give 0.
REQ-021 Opcode 1111 is governed by REQ-028/REQ-029.
REQ-022 Address addition wraps modulo 2^19.

Reset
REQ-023 While reset is high at a rising edge, PC <= 0, all registers <= 0, and the halted flag <= 0; the instruction is not executed.
REQ-024 While reset is high, mem_write = 0, mem_address = 0, and mem_data_out = 0.
REQ-025 Reset has priority over every instruction, including mid-sequence and while halted.
REQ-026 Outputs after reset: pc_out = 0; the memory outputs follow REQ-015..017 for the presented instruction.

Configuration
REQ-027 The macro CPU_HALT_EN selects the behaviour of opcode 1111.
REQ-028 With CPU_HALT_EN defined, 1111 HALT sets the halted flag; PC stays at the HALT address; afterwards no registers change, and mem_write, mem_address and mem_data_out are forced to 0 until reset.
REQ-029 Without CPU_HALT_EN, 1111 is a NOP: PC+1, no other effect; the halted flag does not exist.

Verification
REQ-030 Reset, then LD 1001_00001_00010_00000 with mem_data_in=0x0000F -> mem_address=0, mem_write=0; after the edge R1=0x0000F and pc_out 0->1.
REQ-031 Next, ST 1010_00001_00010_00000 with mem_data_in=0x7FFF0 -> mem_address=0, mem_data_out=0x0000F, mem_write=1; R1 unchanged; pc_out=2.
REQ-032 Load R2=5 and R3=7, ADD 0000_00100_00010_00011, ST R4 -> mem_data_out=12; load 0x7FFFF into R5, INC R5, ST R5 -> 0; LD into R0, then ST R0 -> 0.
REQ-033 JMP with fields 0x1234 -> pc_out=0x01234; at PC=5, BEQ R1,R1 with fc=11110 -> PC=4; BNE R1,R1 -> PC=6.
REQ-034 CPU_HALT_EN defined: HALT at PC=3, then ST on following cycles -> pc_out stays 3, mem_write=0; assert reset for one edge -> pc_out=0 and execution resumes; without the macro, 1111 advances PC to 4.
